// File: rtl/countdown_sequencer.sv
// Sequencer that drives a 4-bit loadable down-counter: loads a start value,
// paces decrements with a prescaler and reports completion on the zero flag.
module countdown_sequencer #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [3:0]            start_value,
  input  logic [PRESCALE_W-1:0] tick_div,
  input  logic                  pause,
  input  logic                  abort,
  input  logic                  zero,
  output logic                  latch,
  output logic [3:0]            load_value,
  output logic                  dec,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            dec_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [PRESCALE_W-1:0] PRESC_ZERO = '0;
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

  state_t                  state_q, state_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic [PRESCALE_W-1:0]   div_q, div_d;
  logic [3:0]              val_q, val_d;
  logic [3:0]              dec_count_q, dec_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= PRESC_ZERO;
      div_q       <= PRESC_ZERO;
      val_q       <= 4'd0;
      dec_count_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      div_q       <= div_d;
      val_q       <= val_d;
      dec_count_q <= dec_count_d;
    end
  end

  // In RUN, abort beats pause, pause beats zero, and zero beats a prescaler tick.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    div_d       = div_q;
    val_d       = val_q;
    dec_count_d = dec_count_q;
    start_ready = 1'b0;
    busy        = 1'b1;
    latch       = 1'b0;
    dec         = 1'b0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) begin
          val_d       = start_value;
          div_d       = tick_div;
          dec_count_d = 4'd0;
          state_d     = S_LOAD;
        end
      end

      // zero is stale until the counter has taken the load, so it is not looked at here
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          latch   = 1'b1;
          presc_d = PRESC_ZERO;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_RUN;
        end else if (zero) begin
          state_d = S_DONE;
        end else if (presc_q == div_q) begin
          dec     = 1'b1;
          presc_d = PRESC_ZERO;
          if (dec_count_q != 4'hF) begin
            dec_count_d = dec_count_q + 4'd1;
          end
        end else begin
          presc_d = presc_q + PRESC_ONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign load_value = val_q;
  assign dec_count  = dec_count_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer: a job-timeline reference model
// checked every cycle, directed scenarios with literal timings, then random traffic.
module tb_countdown_sequencer;

  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [3:0]    start_value;
  logic [PW-1:0] tick_div;
  logic          pause;
  logic          abort;
  logic          zero;
  logic          latch;
  logic [3:0]    load_value;
  logic          dec;
  logic          busy;
  logic          done;
  logic [3:0]    dec_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  countdown_sequencer #(.PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_value (start_value),
    .tick_div    (tick_div),
    .pause       (pause),
    .abort       (abort),
    .zero        (zero),
    .latch       (latch),
    .load_value  (load_value),
    .dec         (dec),
    .busy        (busy),
    .done        (done),
    .dec_count   (dec_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Stand-in for the downstream 4-bit counter, driven by the DUT's strobes.
  logic [3:0] cnt = 4'd0;
  always @(posedge clk) begin
    if (latch) cnt <= load_value;
    else if (dec) cnt <= cnt - 4'd1;
  end
  assign zero = (cnt == 4'd0);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: a job is a timeline position t since accept, frozen by
  // paused RUN cycles. LOAD at t=1, RUN for t=2..2+N(D+1), dec at t=1+i(D+1), DONE after.
  bit modelValid = 1'b0;
  bit mActive    = 1'b0;
  int mT, mN, mD;
  int mLv   = 0;
  int mDcnt = 0;

  always @(negedge clk) begin : compare
    int runEnd;
    bit eLatch, eDec, eDone, eBusy, eReady;
    eLatch = 0; eDec = 0; eDone = 0; eBusy = 0; eReady = 1;
    runEnd = 0;
    if (mActive) begin
      runEnd = 2 + mN * (mD + 1);
      eBusy  = 1;
      eReady = 0;
      if (abort && mT <= runEnd) begin
        eLatch = 0;
      end else if (mT == 1) begin
        eLatch = 1;
      end else if (mT <= runEnd) begin
        eDec = !pause && (mT >= mD + 2) && ((mT - 1) % (mD + 1) == 0) && (mT <= runEnd - 1);
      end else begin
        eDone = 1;
      end
    end
    if (modelValid) begin
      checkOutput("latch", latch, eLatch);
      checkOutput("dec", dec, eDec);
      checkOutput("done", done, eDone);
      checkOutput("busy", busy, eBusy);
      checkOutput("start_ready", start_ready, eReady);
      checkOutput("load_value", load_value, mLv);
      checkOutput("dec_count", dec_count, mDcnt);
      checkOutput("latch_dec_exclusive", latch & dec, 0);
    end
    if (rst) begin
      modelValid = 1;
      mActive    = 0;
      mLv        = 0;
      mDcnt      = 0;
    end else if (modelValid) begin
      if (!mActive) begin
        if (start_valid) begin
          mActive = 1;
          mT      = 1;
          mN      = start_value;
          mD      = tick_div;
          mLv     = start_value;
          mDcnt   = 0;
        end
      end else if (abort && mT <= runEnd) begin
        mActive = 0;
      end else if (mT == 1) begin
        mT = 2;
      end else if (mT <= runEnd) begin
        if (!pause) begin
          if (eDec && mDcnt < 15) mDcnt++;
          mT++;
        end
      end else begin
        mActive = 0;
      end
    end
  end

  // Event log for the directed scenarios, in cycles relative to the accept.
  bit logOn = 1'b0;
  int jobStart, doneRel, latchRel, latchVal, readyRel, busyCount;
  int doneTotal = 0;
  int decLog[$];

  always @(negedge clk) begin : monitor
    if (done) doneTotal++;
    if (logOn) begin
      if (dec) decLog.push_back(cyc - jobStart);
      if (latch) begin
        latchRel = cyc - jobStart;
        latchVal = load_value;
      end
      if (done) doneRel = cyc - jobStart;
      if (busy) busyCount++;
      if (start_ready && readyRel < 0 && cyc > jobStart) readyRel = cyc - jobStart;
    end
  end

  task automatic applyStimulus(input int n, input int d, input int pFrom, input int pTo,
                               input int abortAt, input int rstAt, input int runCycles);
    int waitc;
    waitc = 0;
    @(posedge clk); #1;
    while (!start_ready && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    checkOutput("ready_before_job", start_ready, 1);
    decLog.delete();
    doneRel = -1; latchRel = -1; latchVal = -1; readyRel = -1; busyCount = 0;
    jobStart    = cyc;
    logOn       = 1;
    start_valid = 1;
    start_value = 4'(n);
    tick_div    = PW'(d);
    pause       = 0;
    abort       = 0;
    for (int rel = 1; rel <= runCycles; rel++) begin
      @(posedge clk); #1;
      start_valid = 0;
      pause       = (rel >= pFrom && rel <= pTo);
      abort       = (rel == abortAt);
      rst         = (rel == rstAt);
    end
    @(negedge clk); #1;
    logOn = 0;
  endtask

  initial begin
    rst = 1; start_valid = 0; start_value = 0; tick_div = 0; pause = 0; abort = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk); #1;
    checkOutput("reset_ready", start_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_latch", latch, 0);
    checkOutput("reset_dec", dec, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_dec_count", dec_count, 0);
    checkOutput("reset_load_value", load_value, 0);

    // Basic countdown N=3 D=0
    applyStimulus(3, 0, 0, -1, -1, -1, 8);
    checkOutput("basic_latch_cycle", latchRel, 1);
    checkOutput("basic_latch_value", latchVal, 3);
    checkOutput("basic_dec_total", decLog.size(), 3);
    if (decLog.size() == 3) begin
      checkOutput("basic_dec1", decLog[0], 2);
      checkOutput("basic_dec2", decLog[1], 3);
      checkOutput("basic_dec3", decLog[2], 4);
    end
    checkOutput("basic_done_cycle", doneRel, 6);
    checkOutput("basic_ready_cycle", readyRel, 7);
    checkOutput("basic_dec_count", dec_count, 3);

    // Prescaled N=2 D=4
    applyStimulus(2, 4, 0, -1, -1, -1, 15);
    checkOutput("presc_dec_total", decLog.size(), 2);
    if (decLog.size() == 2) begin
      checkOutput("presc_dec1", decLog[0], 6);
      checkOutput("presc_dec2", decLog[1], 11);
    end
    checkOutput("presc_done_cycle", doneRel, 13);
    checkOutput("presc_busy_cycles", busyCount, 13);

    // Zero start value N=0 D=7
    applyStimulus(0, 7, 0, -1, -1, -1, 5);
    checkOutput("zero_latch_cycle", latchRel, 1);
    checkOutput("zero_dec_total", decLog.size(), 0);
    checkOutput("zero_done_cycle", doneRel, 3);
    checkOutput("zero_dec_count", dec_count, 0);

    // Pause N=2 D=1, pause high in cycles 3..5
    applyStimulus(2, 1, 3, 5, -1, -1, 12);
    checkOutput("pause_dec_total", decLog.size(), 2);
    if (decLog.size() == 2) begin
      checkOutput("pause_dec1", decLog[0], 6);
      checkOutput("pause_dec2", decLog[1], 8);
    end
    checkOutput("pause_done_cycle", doneRel, 10);

    // Abort N=5 D=2 in cycle 6
    applyStimulus(5, 2, 0, -1, 6, -1, 10);
    checkOutput("abort_dec_total", decLog.size(), 1);
    if (decLog.size() == 1) checkOutput("abort_dec1", decLog[0], 4);
    checkOutput("abort_no_done", doneRel, -1);
    checkOutput("abort_ready_cycle", readyRel, 7);
    checkOutput("abort_dec_count", dec_count, 1);

    // Reset mid-RUN of an N=4 job, then a fresh N=1 job
    applyStimulus(4, 0, 0, -1, -1, 4, 5);
    checkOutput("midrst_no_done", doneRel, -1);
    checkOutput("midrst_latch", latch, 0);
    checkOutput("midrst_dec", dec, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_ready", start_ready, 1);
    checkOutput("midrst_dec_count", dec_count, 0);
    checkOutput("midrst_load_value", load_value, 0);
    applyStimulus(1, 0, 0, -1, -1, -1, 6);
    checkOutput("after_rst_done_cycle", doneRel, 4);
    checkOutput("after_rst_dec_count", dec_count, 1);

    // Random traffic against the reference model
    doneTotal = 0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start_valid = ($urandom_range(0, 2) == 0);
      start_value = 4'($urandom_range(0, 15));
      tick_div    = ($urandom_range(0, 9) == 0) ? PW'($urandom_range(0, 255)) : PW'($urandom_range(0, 3));
      pause       = ($urandom_range(0, 5) == 0);
      abort       = ($urandom_range(0, 59) == 0);
      rst         = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk); #1;
    start_valid = 0; pause = 0; abort = 0; rst = 0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    checkOutput("random_jobs_completed", doneTotal > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
